// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and constants for the sequence detector and its match counter
package seq_det_pkg;

  // Control FSM encoding for the match window counter
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // Report field widths (count width is the default; the counter may override it)
  localparam int unsigned RPT_CNT_W = 8;
  localparam int unsigned RPT_SAT_W = 1;

  // Dropped-report tally width
  localparam int unsigned DROP_W = 8;

  // Detector-facing constants used by the block that drives match_in
  localparam int unsigned      DET_PATTERN_LEN = 4;
  localparam logic [3:0]       DET_PATTERN     = 4'b1011;

  // Saturating increment for the drop tally
  function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rpt_fifo2.sv
// rtl/rpt_fifo2.sv - 2-entry synchronous report FIFO with registered head
module rpt_fifo2
  import seq_det_pkg::*;
#(
  parameter int DW = RPT_CNT_W + RPT_SAT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  output logic          full_o,
  input  logic          pop_i,
  output logic [DW-1:0] head_data_o,
  output logic          empty_o
);

  logic [DW-1:0] mem0_q, mem1_q;
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o     = (cnt_q == 2'd0);
  assign full_o      = (cnt_q == 2'd2);
  assign head_data_o = rd_ptr_q ? mem1_q : mem0_q;

  // A push into a full FIFO only lands when the head leaves on the same edge
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers; memory is cleared so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) mem1_q <= push_data_i;
        else          mem0_q <= push_data_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/match_window_counter.sv
// rtl/match_window_counter.sv - counts detector matches per fixed window and queues per-window reports
module match_window_counter
  import seq_det_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int CNT_W  = RPT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              match_in,
  input  logic              enable,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [CNT_W-1:0]  rpt_count,
  output logic              rpt_sat,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int                 TIMER_W    = $clog2(WINDOW);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW - 1);
  localparam int                 RPT_W      = CNT_W + RPT_SAT_W;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic                sat_acc_q, sat_acc_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                counting, close_win;
  logic                acc_at_max, acc_ovf;
  logic [CNT_W-1:0]    acc_plus;
  logic                rpt_sat_w;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [RPT_W-1:0]    fifo_head;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: enable alone moves between idle and counting
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable)  state_d = ST_COUNT;
      ST_COUNT: if (!enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: enable low wins over a window close on the same cycle
  always_comb begin
    counting  = 1'b0;
    close_win = 1'b0;
    if (state_q == ST_COUNT && enable) begin
      counting  = 1'b1;
      close_win = (timer_q == TIMER_LAST);
    end
  end

  // Saturating accumulate; the close-cycle match is folded into the report
  always_comb begin
    acc_at_max = (acc_q == {CNT_W{1'b1}});
    acc_ovf    = counting & match_in & acc_at_max;
    acc_plus   = (match_in && !acc_at_max) ? acc_q + 1'b1 : acc_q;
    rpt_sat_w  = sat_acc_q | acc_ovf;
  end

  // Window datapath next state: cleared when idle, aborted or closing
  always_comb begin
    timer_d   = '0;
    acc_d     = '0;
    sat_acc_d = 1'b0;
    if (counting && !close_win) begin
      timer_d   = timer_q + 1'b1;
      acc_d     = acc_plus;
      sat_acc_d = rpt_sat_w;
    end
  end

  // A close that finds the buffer full with no pop loses its report
  always_comb begin
    fifo_pop = ~fifo_empty & rpt_ready;
    drop_d   = drop_q;
    if (close_win && fifo_full && !fifo_pop) drop_d = drop_sat_inc(drop_q);
  end

  // Window datapath and drop tally registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      acc_q     <= '0;
      sat_acc_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      timer_q   <= timer_d;
      acc_q     <= acc_d;
      sat_acc_q <= sat_acc_d;
      drop_q    <= drop_d;
    end
  end

  rpt_fifo2 #(
    .DW (RPT_W)
  ) u_rpt_fifo2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (close_win),
    .push_data_i ({rpt_sat_w, acc_plus}),
    .full_o      (fifo_full),
    .pop_i       (fifo_pop),
    .head_data_o (fifo_head),
    .empty_o     (fifo_empty)
  );

  assign rpt_valid            = ~fifo_empty;
  assign {rpt_sat, rpt_count} = fifo_head;
  assign drop_cnt             = drop_q;

endmodule

// File: tb/tb_match_window_counter.sv
// tb/tb_match_window_counter.sv - self-checking bench for match_window_counter
module tb_match_window_counter;

  localparam int WINDOW = 8;
  localparam int CNT_W  = 3;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             match_in = 1'b0;
  logic             enable = 1'b0;
  logic             rpt_ready = 1'b0;
  logic             rpt_valid;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_sat;
  logic [7:0]       drop_cnt;

  match_window_counter #(
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .match_in  (match_in),
    .enable    (enable),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_count (rpt_count),
    .rpt_sat   (rpt_sat),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a report queue plus a window described by position and match total
  typedef struct {
    int count;
    bit sat;
  } rpt_t;

  rpt_t mq[$];
  bit   m_active;
  int   m_pos;
  int   m_sum;
  int   m_drops;

  typedef struct {
    bit en;
    bit m;
    bit rdy;
    bit exp_valid;
    int exp_count;
    bit exp_sat;
    int exp_drop;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_sum    = 0;
    m_drops  = 0;
  endtask

  task automatic model_edge(input bit en, input bit m, input bit rdy);
    bit   pop;
    bit   push;
    rpt_t r;
    pop  = (mq.size() > 0) && rdy;
    push = 1'b0;
    r.count = 0;
    r.sat   = 1'b0;
    if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_sum    = 0;
      end
    end else if (!en) begin
      m_active = 1'b0;
    end else begin
      m_pos++;
      m_sum += int'(m);
      if (m_pos == WINDOW) begin
        r.count = (m_sum > MAXC) ? MAXC : m_sum;
        r.sat   = (m_sum > MAXC);
        push    = 1'b1;
        m_pos   = 0;
        m_sum   = 0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < 2) mq.push_back(r);
      else if (m_drops < 255) m_drops++;
    end
  endtask

  task automatic check_model();
    check("model_valid", int'(rpt_valid), int'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("model_count", int'(rpt_count), mq[0].count);
      check("model_sat", int'(rpt_sat), int'(mq[0].sat));
    end
    check("model_drop", int'(drop_cnt), m_drops);
  endtask

  task automatic cycle(input bit en, input bit m, input bit rdy);
    enable    = en;
    match_in  = m;
    rpt_ready = rdy;
    @(posedge clk);
    model_edge(en, m, rdy);
    #1;
    check_model();
  endtask

  task automatic window(input logic [7:0] pat, input bit rdy, input bit rdy_close);
    for (int i = 0; i < WINDOW; i++) cycle(1'b1, pat[i], (i == WINDOW - 1) ? rdy_close : rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", int'(rpt_valid), 0);
    check("rst_count", int'(rpt_count), 0);
    check("rst_sat", int'(rpt_sat), 0);
    check("rst_drop", int'(drop_cnt), 0);
    enable    = 1'b0;
    match_in  = 1'b0;
    rpt_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    check_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // en, m, rdy, exp_valid, exp_count, exp_sat, exp_drop
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b0, 0};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0};

    #3;
    do_reset();

    // Basic count: matches on counted cycles 1, 4 and 8
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].en, tbl[i].m, tbl[i].rdy);
      check("tbl_valid", int'(rpt_valid), int'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        check("tbl_count", int'(rpt_count), tbl[i].exp_count);
        check("tbl_sat", int'(rpt_sat), int'(tbl[i].exp_sat));
      end
      check("tbl_drop", int'(drop_cnt), tbl[i].exp_drop);
    end
    cycle(1'b0, 1'b0, 1'b1);

    // Saturation, then a clean window afterwards
    cycle(1'b1, 1'b0, 1'b1);
    window(8'hFF, 1'b1, 1'b1);
    check("sat_valid", int'(rpt_valid), 1);
    check("sat_count", int'(rpt_count), 7);
    check("sat_flag", int'(rpt_sat), 1);
    window(8'b0001_0010, 1'b1, 1'b1);
    check("post_sat_count", int'(rpt_count), 2);
    check("post_sat_flag", int'(rpt_sat), 0);
    cycle(1'b0, 1'b0, 1'b1);

    // Back-pressure: third report dropped, head held
    cycle(1'b1, 1'b0, 1'b0);
    window(8'b0000_0001, 1'b0, 1'b0);
    check("bp_head1", int'(rpt_count), 1);
    window(8'b0000_0011, 1'b0, 1'b0);
    check("bp_head2", int'(rpt_count), 1);
    check("bp_drop0", int'(drop_cnt), 0);
    window(8'b0000_0111, 1'b0, 1'b0);
    check("bp_drop1", int'(drop_cnt), 1);
    check("bp_head3", int'(rpt_count), 1);
    cycle(1'b0, 1'b0, 1'b1);
    check("bp_second", int'(rpt_count), 2);
    cycle(1'b0, 1'b0, 1'b1);
    check("bp_empty", int'(rpt_valid), 0);

    // Simultaneous push and pop on a full buffer
    cycle(1'b1, 1'b0, 1'b0);
    window(8'b0000_0001, 1'b0, 1'b0);
    window(8'b0000_0011, 1'b0, 1'b0);
    window(8'b0000_0111, 1'b0, 1'b1);
    check("pp_drop", int'(drop_cnt), 1);
    check("pp_head", int'(rpt_count), 2);
    cycle(1'b0, 1'b0, 1'b1);
    check("pp_next", int'(rpt_count), 3);
    cycle(1'b0, 1'b0, 1'b1);
    check("pp_empty", int'(rpt_valid), 0);

    // Enable abort after 5 counted cycles with 2 matches
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("abort_no_rpt", int'(rpt_valid), 0);
    cycle(1'b1, 1'b0, 1'b1);
    window(8'b1000_0000, 1'b1, 1'b1);
    check("abort_fresh_count", int'(rpt_count), 1);
    check("abort_fresh_sat", int'(rpt_sat), 0);
    cycle(1'b0, 1'b0, 1'b1);

    // Reset mid-window with one report buffered; then confirm idle entry
    cycle(1'b1, 1'b0, 1'b0);
    window(8'b0000_0101, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 1'b1, 1'b1);
    window(8'h00, 1'b1, 1'b1);
    check("post_rst_count", int'(rpt_count), 0);
    check("post_rst_valid", int'(rpt_valid), 1);
    cycle(1'b0, 1'b0, 1'b1);

    // Drop tally saturates at 255
    cycle(1'b1, 1'b0, 1'b0);
    for (int w = 0; w < 260; w++) window(8'h01, 1'b0, 1'b0);
    check("drop_sat", int'(drop_cnt), 255);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 15) != 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
